lfsr_monitor: RTL and testbench
===============================

LFSR_MONITOR -- requirements
Module: lfsr_monitor

Interface
REQ-001 Parameter CW, default 13: width of all count inputs, counters and count outputs.
REQ-002 Parameter EXP_ONES, default 2048: expected ones per LFSR period.
REQ-003 Parameter EXP_ZEROS, default 2047: expected zeros per LFSR period.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 lfsr_out  input  1  upstream serial LFSR bit, one new bit per clk.
REQ-007 max_tick  input  1  one-cycle pulse on the last bit of a period; upstream counts are final on that cycle.
REQ-008 count_zero  input  CW  upstream zero count.
REQ-009 count_one  input  CW  upstream one count.
REQ-010 result_ready  input  1  consumer accepts result.
REQ-011 result_valid  output  1  result registers hold an unaccepted result.
REQ-012 res_ones, res_zeros  output  CW each  locally counted ones/zeros of the reported period.
REQ-013 res_run_one, res_run_zero  output  5 each  longest run of ones/zeros in the reported period, saturating at 31.
REQ-014 res_pass  output  1  reported period passed all checks.
REQ-015 period_cnt  output  16  number of completed, checked periods, wraps at 65535->0.
REQ-016 err_mismatch, err_overrun, err_timeout  output  1 each  sticky error flags.

Function
REQ-017 FSM states: SYNC, RUN, CHECK; reset enters SYNC.
REQ-018 SYNC: ignore lfsr_out; on max_tick go to RUN; local counters cleared so bit at the next cycle is first of a period.
REQ-019 RUN: each cycle increment local ones or zeros per lfsr_out, saturating at 2^CW-1; track current run length and value, update running maxima (saturate 31).
REQ-020 Run tracking restarts at the first bit of each period; runs spanning a period boundary are split.
REQ-021 RUN with max_tick at cycle t: bit t is included; snapshot local counts, run maxima, count_one, count_zero at the edge ending t; go to CHECK; local counters and run state restart for bit t+1 with no lost bit.
REQ-022 CHECK (one cycle, t+1): pass = (local ones == EXP_ONES) && (local zeros == EXP_ZEROS) && (local ones == count_one snapshot) && (local zeros == count_zero snapshot); return to RUN; bit t+1 is counted normally.
REQ-023 Result load at edge ending CHECK: result_valid high from cycle t+2; period_cnt increments by 1 at the same edge.
REQ-024 If pass is 0 at CHECK, err_mismatch sets at the same edge as result load.
REQ-025 Handshake: transfer when result_valid && result_ready; result_valid clears next edge unless a new result loads on that same edge.
REQ-026 Result load while result_valid=1 and result_ready=0: new result discarded, old result held unchanged, err_overrun sets; period_cnt still increments.
REQ-027 Result load while result_valid=1 and result_ready=1: old result transfers, new result loads, result_valid stays 1.
REQ-028 Result outputs change only on load; stable while result_valid=1 and not transferred.
REQ-029 Timeout: in RUN, if local ones+zeros reaches 2^CW-1 without max_tick, err_timeout sets; counters hold saturated until next max_tick.
REQ-030 max_tick while in CHECK (period of 1 bit): treated as period end for that bit; same snapshot/CHECK sequence, result at next CHECK.
REQ-031 Error flags clear only on reset.

Reset
REQ-032 On reset high at any clock edge, including mid-period or mid-handshake: state SYNC; all counters, run trackers, snapshots, result outputs, period_cnt, error flags = 0; result_valid = 0.
REQ-033 Reset takes priority over max_tick, result_ready and all counting in the same cycle.

Verification
REQ-034 Upstream 12-bit maximal LFSR, reset 10 cycles, result_ready=1 -> first result_valid two cycles after second max_tick; res_ones=2048, res_zeros=2047, res_run_one=12, res_run_zero=11 (if run not split), res_pass=1, period_cnt=1, no errors.
REQ-035 Model drives count_one=2047 at max_tick, local counts correct -> res_pass=0, err_mismatch=1, result_valid=1.
REQ-036 result_ready=0 across two periods -> first result held, err_overrun=1, period_cnt=2; then ready=1 for one cycle -> result_valid=0 next cycle.
REQ-037 max_tick tied 0 after first pulse -> err_timeout=1 exactly when local count reaches 8191; no result_valid.
REQ-038 reset pulsed at bit 1000 of a period with result_valid=1 -> all outputs 0 next edge; next result only after two further max_tick pulses, res_pass=1.
REQ-039 result_ready high on the load edge with result_valid=1 -> result_valid remains 1, outputs take new values, err_overrun=0.

Source files
------------

// File: rtl/lfsr_monitor.sv
// Period-by-period checker for a serial LFSR stream: local ones/zeros counts, longest runs,
// comparison against expected and upstream counts, reported through a valid/ready result port.
module lfsr_monitor #(
    parameter int unsigned CW        = 13,
    parameter int unsigned EXP_ONES  = 2048,
    parameter int unsigned EXP_ZEROS = 2047
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          lfsr_out,
    input  logic          max_tick,
    input  logic [CW-1:0] count_zero,
    input  logic [CW-1:0] count_one,
    input  logic          result_ready,
    output logic          result_valid,
    output logic [CW-1:0] res_ones,
    output logic [CW-1:0] res_zeros,
    output logic [4:0]    res_run_one,
    output logic [4:0]    res_run_zero,
    output logic          res_pass,
    output logic [15:0]   period_cnt,
    output logic          err_mismatch,
    output logic          err_overrun,
    output logic          err_timeout
);
    localparam logic [CW-1:0] ExpOnes  = CW'(EXP_ONES);
    localparam logic [CW-1:0] ExpZeros = CW'(EXP_ZEROS);
    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [CW:0]   TotalMax = {1'b0, {CW{1'b1}}};
    localparam logic [4:0]    RunMax   = 5'd31;

    typedef enum logic [1:0] {StSync, StRun, StCheck} state_e;
    state_e state_q;

    logic [CW-1:0] ones_q, zeros_q;
    logic [4:0]    run_len_q, max_one_q, max_zero_q;
    logic          run_val_q;

    logic [CW-1:0] snap_ones_q, snap_zeros_q, snap_cnt_one_q, snap_cnt_zero_q;
    logic [4:0]    snap_run_one_q, snap_run_zero_q;

    logic          cnt_en;
    logic [CW:0]   total_q, total_nx;
    logic [CW-1:0] ones_nx, zeros_nx;
    logic [4:0]    run_len_nx, max_one_nx, max_zero_nx;
    logic          run_val_nx;
    logic          pass_c;

    always_comb begin
        total_q     = {1'b0, ones_q} + {1'b0, zeros_q};
        // Once the total saturates, everything holds until the next period end.
        cnt_en      = (state_q != StSync) && (total_q != TotalMax);
        ones_nx     = ones_q;
        zeros_nx    = zeros_q;
        run_len_nx  = run_len_q;
        run_val_nx  = run_val_q;
        max_one_nx  = max_one_q;
        max_zero_nx = max_zero_q;
        if (cnt_en) begin
            if (lfsr_out) begin
                ones_nx = ones_q + CntOne;
            end else begin
                zeros_nx = zeros_q + CntOne;
            end
            if ((run_len_q != 5'd0) && (run_val_q == lfsr_out)) begin
                run_len_nx = (run_len_q == RunMax) ? RunMax : run_len_q + 5'd1;
            end else begin
                run_len_nx = 5'd1;
            end
            run_val_nx = lfsr_out;
            if (lfsr_out && (run_len_nx > max_one_q)) begin
                max_one_nx = run_len_nx;
            end
            if (!lfsr_out && (run_len_nx > max_zero_q)) begin
                max_zero_nx = run_len_nx;
            end
        end
        total_nx = {1'b0, ones_nx} + {1'b0, zeros_nx};
        pass_c   = (snap_ones_q == ExpOnes) && (snap_zeros_q == ExpZeros) &&
                   (snap_ones_q == snap_cnt_one_q) && (snap_zeros_q == snap_cnt_zero_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StSync;
            ones_q          <= '0;
            zeros_q         <= '0;
            run_len_q       <= '0;
            run_val_q       <= 1'b0;
            max_one_q       <= '0;
            max_zero_q      <= '0;
            snap_ones_q     <= '0;
            snap_zeros_q    <= '0;
            snap_cnt_one_q  <= '0;
            snap_cnt_zero_q <= '0;
            snap_run_one_q  <= '0;
            snap_run_zero_q <= '0;
            result_valid    <= 1'b0;
            res_ones        <= '0;
            res_zeros       <= '0;
            res_run_one     <= '0;
            res_run_zero    <= '0;
            res_pass        <= 1'b0;
            period_cnt      <= '0;
            err_mismatch    <= 1'b0;
            err_overrun     <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end

            case (state_q)
                StSync: begin
                    if (max_tick) begin
                        state_q    <= StRun;
                        ones_q     <= '0;
                        zeros_q    <= '0;
                        run_len_q  <= '0;
                        run_val_q  <= 1'b0;
                        max_one_q  <= '0;
                        max_zero_q <= '0;
                    end
                end
                StRun, StCheck: begin
                    if (max_tick) begin
                        // Current bit closes the period; the next bit starts a fresh one.
                        state_q         <= StCheck;
                        snap_ones_q     <= ones_nx;
                        snap_zeros_q    <= zeros_nx;
                        snap_run_one_q  <= max_one_nx;
                        snap_run_zero_q <= max_zero_nx;
                        snap_cnt_one_q  <= count_one;
                        snap_cnt_zero_q <= count_zero;
                        ones_q          <= '0;
                        zeros_q         <= '0;
                        run_len_q       <= '0;
                        run_val_q       <= 1'b0;
                        max_one_q       <= '0;
                        max_zero_q      <= '0;
                    end else begin
                        state_q    <= StRun;
                        ones_q     <= ones_nx;
                        zeros_q    <= zeros_nx;
                        run_len_q  <= run_len_nx;
                        run_val_q  <= run_val_nx;
                        max_one_q  <= max_one_nx;
                        max_zero_q <= max_zero_nx;
                        if ((state_q == StRun) && cnt_en && (total_nx == TotalMax)) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: state_q <= StSync;
            endcase

            if (state_q == StCheck) begin
                period_cnt <= period_cnt + 16'd1;
                if (!pass_c) begin
                    err_mismatch <= 1'b1;
                end
                if (result_valid && !result_ready) begin
                    err_overrun <= 1'b1;
                end else begin
                    result_valid <= 1'b1;
                    res_ones     <= snap_ones_q;
                    res_zeros    <= snap_zeros_q;
                    res_run_one  <= snap_run_one_q;
                    res_run_zero <= snap_run_zero_q;
                    res_pass     <= pass_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_monitor.sv
// Directed bench for lfsr_monitor: a 12-bit maximal LFSR upstream with max_tick placed on the
// last bit of the 12-ones run, plus hand-built short periods.
module tb_lfsr_monitor;
    localparam int unsigned CW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lfsr_out = 1'b0;
    logic          max_tick = 1'b0;
    logic [CW-1:0] count_zero = 13'd2047;
    logic [CW-1:0] count_one = 13'd2048;
    logic          result_ready = 1'b1;
    logic          result_valid;
    logic [CW-1:0] res_ones, res_zeros;
    logic [4:0]    res_run_one, res_run_zero;
    logic          res_pass;
    logic [15:0]   period_cnt;
    logic          err_mismatch, err_overrun, err_timeout;

    int n_checks = 0;
    int n_fail = 0;

    logic [11:0] s = 12'h001;
    logic [10:0] hist = '0;
    logic        tick_en = 1'b1;
    logic        ticked = 1'b0;

    lfsr_monitor #(.CW(CW), .EXP_ONES(2048), .EXP_ZEROS(2047)) dut (
        .clk          (clk),
        .reset        (reset),
        .lfsr_out     (lfsr_out),
        .max_tick     (max_tick),
        .count_zero   (count_zero),
        .count_one    (count_one),
        .result_ready (result_ready),
        .result_valid (result_valid),
        .res_ones     (res_ones),
        .res_zeros    (res_zeros),
        .res_run_one  (res_run_one),
        .res_run_zero (res_run_zero),
        .res_pass     (res_pass),
        .period_cnt   (period_cnt),
        .err_mismatch (err_mismatch),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input logic t);
        lfsr_out = b;
        max_tick = t;
        @(posedge clk);
        #1;
    endtask

    // One LFSR bit; x^12+x^6+x^4+x+1, output is s[0].
    task automatic step();
        logic b, t;
        b = s[0];
        t = tick_en && (hist == 11'h7FF) && b;
        drive(b, t);
        ticked = t;
        hist = {hist[9:0], b};
        s = {s[6] ^ s[4] ^ s[1] ^ s[0], s[11:1]};
    endtask

    task automatic run_to_tick(input string tag);
        int n;
        n = 0;
        ticked = 1'b0;
        while (!ticked && (n < 5000)) begin
            step();
            n++;
        end
        chk(tag, 32'(ticked), 32'd1);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_ones"}, 32'(res_ones), 32'd0);
        chk({tag, "_zeros"}, 32'(res_zeros), 32'd0);
        chk({tag, "_run1"}, 32'(res_run_one), 32'd0);
        chk({tag, "_run0"}, 32'(res_run_zero), 32'd0);
        chk({tag, "_pass"}, 32'(res_pass), 32'd0);
        chk({tag, "_pcnt"}, 32'(period_cnt), 32'd0);
        chk({tag, "_mism"}, 32'(err_mismatch), 32'd0);
        chk({tag, "_ovr"}, 32'(err_overrun), 32'd0);
        chk({tag, "_tmo"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        // Reset and first full LFSR period
        repeat (10) step();
        chk_cleared("rst");
        reset = 1'b0;
        run_to_tick("sync1");
        run_to_tick("end1");
        chk("check_no_valid", 32'(result_valid), 32'd0);
        step();
        chk("p1_valid", 32'(result_valid), 32'd1);
        chk("p1_ones", 32'(res_ones), 32'd2048);
        chk("p1_zeros", 32'(res_zeros), 32'd2047);
        chk("p1_run1", 32'(res_run_one), 32'd12);
        chk("p1_run0", 32'(res_run_zero), 32'd11);
        chk("p1_pass", 32'(res_pass), 32'd1);
        chk("p1_pcnt", 32'(period_cnt), 32'd1);
        chk("p1_mism", 32'(err_mismatch), 32'd0);
        chk("p1_ovr", 32'(err_overrun), 32'd0);
        chk("p1_tmo", 32'(err_timeout), 32'd0);
        step();
        chk("p1_xfer", 32'(result_valid), 32'd0);

        // Upstream count disagrees
        count_one = 13'd2047;
        run_to_tick("end2");
        step();
        count_one = 13'd2048;
        chk("mm_valid", 32'(result_valid), 32'd1);
        chk("mm_pass", 32'(res_pass), 32'd0);
        chk("mm_ones", 32'(res_ones), 32'd2048);
        chk("mm_err", 32'(err_mismatch), 32'd1);
        chk("mm_pcnt", 32'(period_cnt), 32'd2);

        reset = 1'b1;
        step();
        chk_cleared("rst2");
        reset = 1'b0;

        // Load with ready high on the load edge, then overrun
        result_ready = 1'b0;
        run_to_tick("sync2");
        run_to_tick("e1");
        step();
        chk("e1_valid", 32'(result_valid), 32'd1);
        chk("e1_pass", 32'(res_pass), 32'd1);
        chk("e1_pcnt", 32'(period_cnt), 32'd1);
        count_one = 13'd2047;
        run_to_tick("e2");
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        count_one = 13'd2048;
        chk("e2_valid", 32'(result_valid), 32'd1);
        chk("e2_pass_new", 32'(res_pass), 32'd0);
        chk("e2_ovr", 32'(err_overrun), 32'd0);
        chk("e2_pcnt", 32'(period_cnt), 32'd2);
        run_to_tick("d3");
        step();
        chk("d3_valid", 32'(result_valid), 32'd1);
        chk("d3_pass_held", 32'(res_pass), 32'd0);
        chk("d3_ovr", 32'(err_overrun), 32'd1);
        chk("d3_pcnt", 32'(period_cnt), 32'd3);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("d3_xfer", 32'(result_valid), 32'd0);

        // Reset at bit 1000 with a result pending
        run_to_tick("f1");
        step();
        chk("f1_valid", 32'(result_valid), 32'd1);
        chk("f1_pcnt", 32'(period_cnt), 32'd4);
        repeat (998) step();
        reset = 1'b1;
        step();
        chk_cleared("rst3");
        reset = 1'b0;
        result_ready = 1'b1;
        run_to_tick("f_sync");
        chk("f_sync_valid", 32'(result_valid), 32'd0);
        run_to_tick("f_end");
        step();
        chk("f_valid", 32'(result_valid), 32'd1);
        chk("f_pass", 32'(res_pass), 32'd1);
        chk("f_ones", 32'(res_ones), 32'd2048);
        chk("f_run0", 32'(res_run_zero), 32'd11);
        chk("f_pcnt", 32'(period_cnt), 32'd1);

        // No further max_tick: timeout at the 8191st local bit
        tick_en = 1'b0;
        repeat (8189) step();
        chk("tmo_early", 32'(err_timeout), 32'd0);
        chk("tmo_early_valid", 32'(result_valid), 32'd0);
        step();
        chk("tmo_set", 32'(err_timeout), 32'd1);
        chk("tmo_valid", 32'(result_valid), 32'd0);
        chk("tmo_pcnt", 32'(period_cnt), 32'd1);

        // Hand-built short periods; max_tick during reset must be ignored
        reset = 1'b1;
        drive(1'b0, 1'b1);
        reset = 1'b0;
        chk("h_rst_tmo", 32'(err_timeout), 32'd0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        count_one = 13'd2;
        count_zero = 13'd1;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        chk("hA_no_valid", 32'(result_valid), 32'd0);
        drive(1'b1, 1'b1);
        chk("hA_valid", 32'(result_valid), 32'd1);
        chk("hA_ones", 32'(res_ones), 32'd2);
        chk("hA_zeros", 32'(res_zeros), 32'd1);
        chk("hA_run1", 32'(res_run_one), 32'd2);
        chk("hA_run0", 32'(res_run_zero), 32'd1);
        chk("hA_pass", 32'(res_pass), 32'd0);
        chk("hA_pcnt", 32'(period_cnt), 32'd1);
        drive(1'b0, 1'b0);
        chk("hB_valid", 32'(result_valid), 32'd1);
        chk("hB_ones", 32'(res_ones), 32'd1);
        chk("hB_zeros", 32'(res_zeros), 32'd0);
        chk("hB_run1", 32'(res_run_one), 32'd1);
        chk("hB_run0", 32'(res_run_zero), 32'd0);
        chk("hB_pcnt", 32'(period_cnt), 32'd2);
        repeat (33) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        chk("hC_ones", 32'(res_ones), 32'd34);
        chk("hC_zeros", 32'(res_zeros), 32'd1);
        chk("hC_run1_sat", 32'(res_run_one), 32'd31);
        chk("hC_run0", 32'(res_run_zero), 32'd1);
        chk("hC_pcnt", 32'(period_cnt), 32'd3);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        chk("hD_ones", 32'(res_ones), 32'd2);
        chk("hD_zeros", 32'(res_zeros), 32'd0);
        chk("hD_run1_split", 32'(res_run_one), 32'd2);
        chk("hD_pcnt", 32'(period_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
